// File: rtl/active_list_rob_if.sv
// Dispatch / writeback / flush / free-return bundle of the active list.
interface active_list_rob_if #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int FREE_LIST_WIDTH  = 3,
  parameter int CHECKPOINT_WIDTH = 2
);
  logic                        i_Alloc_Valid;
  logic [REG_ADDR_WIDTH:0]     i_Alloc_New_PReg;
  logic [REG_ADDR_WIDTH:0]     i_Alloc_Old_PReg;
  logic [CHECKPOINT_WIDTH-1:0] i_Alloc_Checkpoint;
  logic                        o_Alloc_Ready;
  logic [FREE_LIST_WIDTH-1:0]  o_Alloc_Index;
  logic                        i_WB_Valid;
  logic [FREE_LIST_WIDTH-1:0]  i_WB_Index;
  logic                        i_Commit_Enable;
  logic                        i_Flush;
  logic [FREE_LIST_WIDTH-1:0]  i_Flush_Tail;
  logic                        o_Free_Valid;
  logic [REG_ADDR_WIDTH:0]     o_Free_PReg;
  logic                        i_Free_Ready;
  logic [CHECKPOINT_WIDTH-1:0] o_Retire_Checkpoint;
  logic [FREE_LIST_WIDTH:0]    o_Count;
  logic                        o_Empty;
  logic                        o_Full;
  logic                        o_Busy;

  modport master (
    output i_Alloc_Valid, i_Alloc_New_PReg, i_Alloc_Old_PReg, i_Alloc_Checkpoint,
           i_WB_Valid, i_WB_Index, i_Commit_Enable, i_Flush, i_Flush_Tail, i_Free_Ready,
    input  o_Alloc_Ready, o_Alloc_Index, o_Free_Valid, o_Free_PReg, o_Retire_Checkpoint,
           o_Count, o_Empty, o_Full, o_Busy
  );

  modport slave (
    input  i_Alloc_Valid, i_Alloc_New_PReg, i_Alloc_Old_PReg, i_Alloc_Checkpoint,
           i_WB_Valid, i_WB_Index, i_Commit_Enable, i_Flush, i_Flush_Tail, i_Free_Ready,
    output o_Alloc_Ready, o_Alloc_Index, o_Free_Valid, o_Free_PReg, o_Retire_Checkpoint,
           o_Count, o_Empty, o_Full, o_Busy
  );
endinterface

// File: rtl/active_list_rob.sv
// Active list: in-order retirement returns old pregs; mispredict walk returns
// squashed new pregs youngest-first, one per cycle.
module active_list_rob #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int FREE_LIST_WIDTH  = 3,
  parameter int CHECKPOINT_WIDTH = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  active_list_rob_if.slave rob
);
  localparam int PW    = REG_ADDR_WIDTH + 1;
  localparam int FW    = FREE_LIST_WIDTH;
  localparam int DEPTH = 2 ** FW;

  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, state_n;

  logic [DEPTH-1:0]                       valid_q, done_q;
  logic [DEPTH-1:0][PW-1:0]               new_q, old_q;
  logic [DEPTH-1:0][CHECKPOINT_WIDTH-1:0] ckpt_q;
  logic [FW-1:0] head, tail, walk, stop;
  logic [FW:0]   count;

  logic full, alloc_ready, free_valid;
  logic [PW-1:0] free_preg;
  logic do_alloc, do_retire, do_walk, start_flush, do_dec;

  assign full = (count == DEPTH[FW:0]);

  always_comb begin
    state_n     = state;
    alloc_ready = 1'b0;
    free_valid  = 1'b0;
    free_preg   = old_q[head];
    do_alloc    = 1'b0;
    do_retire   = 1'b0;
    do_walk     = 1'b0;
    start_flush = 1'b0;
    case (state)
      RUN: begin
        alloc_ready = !full;
        // Flush wins: neither allocate nor retire happen in the flush cycle
        if (rob.i_Flush) begin
          start_flush = 1'b1;
          if (rob.i_Flush_Tail != tail) state_n = SQUASH;
        end else begin
          free_valid = valid_q[head] && done_q[head] && rob.i_Commit_Enable;
          do_retire  = free_valid && rob.i_Free_Ready;
          do_alloc   = rob.i_Alloc_Valid && alloc_ready;
        end
      end
      SQUASH: begin
        free_valid = 1'b1;
        free_preg  = new_q[walk];
        do_walk    = rob.i_Free_Ready;
        if (do_walk && walk == stop) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign do_dec = do_retire || do_walk;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= RUN;
    else         state <= state_n;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      head    <= '0;
      tail    <= '0;
      walk    <= '0;
      stop    <= '0;
      count   <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (rob.i_WB_Valid && valid_q[rob.i_WB_Index]) done_q[rob.i_WB_Index] <= 1'b1;
      if (start_flush) begin
        walk <= tail - 1'b1;
        stop <= rob.i_Flush_Tail;
      end
      if (do_retire) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (do_alloc) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      // Walk retreats the tail so the list stays consistent if it stalls
      if (do_walk) begin
        valid_q[walk] <= 1'b0;
        done_q[walk]  <= 1'b0;
        tail          <= walk;
        walk          <= walk - 1'b1;
      end
      if (do_alloc && !do_dec)      count <= count + 1'b1;
      else if (!do_alloc && do_dec) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_alloc) begin
      new_q[tail]  <= rob.i_Alloc_New_PReg;
      old_q[tail]  <= rob.i_Alloc_Old_PReg;
      ckpt_q[tail] <= rob.i_Alloc_Checkpoint;
    end
  end

  assign rob.o_Alloc_Ready       = alloc_ready;
  assign rob.o_Alloc_Index       = tail;
  assign rob.o_Free_Valid        = free_valid;
  assign rob.o_Free_PReg         = free_preg;
  assign rob.o_Retire_Checkpoint = ckpt_q[head];
  assign rob.o_Count             = count;
  assign rob.o_Empty             = (count == '0);
  assign rob.o_Full              = full;
  assign rob.o_Busy              = (state == SQUASH);
endmodule

// File: tb/tb_active_list_rob.sv
// Directed bench for active_list_rob: retire, full/wrap, commit gating,
// flush walk with wrap, flush priority, reset during walk.
module tb_active_list_rob;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  active_list_rob_if #(.REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3), .CHECKPOINT_WIDTH(2)) bus();

  active_list_rob #(.REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3), .CHECKPOINT_WIDTH(2)) dut (
    .i_Clk(clk), .i_Reset(rst), .rob(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_Alloc_Valid = 0; bus.i_Alloc_New_PReg = '0; bus.i_Alloc_Old_PReg = '0;
    bus.i_Alloc_Checkpoint = '0; bus.i_WB_Valid = 0; bus.i_WB_Index = '0;
    bus.i_Commit_Enable = 0; bus.i_Flush = 0; bus.i_Flush_Tail = '0; bus.i_Free_Ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic alloc(input int np, input int op, input int ck, input int exp_idx);
    bus.i_Alloc_Valid = 1; bus.i_Alloc_New_PReg = 6'(np);
    bus.i_Alloc_Old_PReg = 6'(op); bus.i_Alloc_Checkpoint = 2'(ck);
    #1;
    chk("alloc_ready", bus.o_Alloc_Ready, 1);
    chk("alloc_index", bus.o_Alloc_Index, exp_idx);
    tick();
    bus.i_Alloc_Valid = 0;
  endtask

  task automatic wb(input int idx);
    bus.i_WB_Valid = 1; bus.i_WB_Index = 3'(idx);
    tick();
    bus.i_WB_Valid = 0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_free_valid", bus.o_Free_Valid, 0);
    chk("rst_alloc_ready", bus.o_Alloc_Ready, 1);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_empty", bus.o_Empty, 1);
    chk("rst_full", bus.o_Full, 0);
    chk("rst_alloc_index", bus.o_Alloc_Index, 0);
    chk("rst_count", bus.o_Count, 0);

    // basic in-order retire
    for (int i = 0; i < 3; i++) alloc(32 + i, 1 + i, i, i);
    chk("t1_count3", bus.o_Count, 3);
    wb(1);
    wb(0);
    bus.i_Commit_Enable = 1; bus.i_Free_Ready = 1;
    #1;
    chk("t1_fv0", bus.o_Free_Valid, 1);
    chk("t1_preg0", bus.o_Free_PReg, 1);
    chk("t1_ckpt0", bus.o_Retire_Checkpoint, 0);
    tick();
    chk("t1_preg1", bus.o_Free_PReg, 2);
    chk("t1_ckpt1", bus.o_Retire_Checkpoint, 1);
    chk("t1_count2", bus.o_Count, 2);
    tick();
    chk("t1_fv_notdone", bus.o_Free_Valid, 0);
    chk("t1_count1", bus.o_Count, 1);
    tick();
    chk("t1_count_hold", bus.o_Count, 1);

    // full, dropped request, wrap with alloc+retire
    do_reset();
    for (int i = 0; i < 8; i++) alloc(8 + i, 10 + i, i % 4, i);
    chk("t2_full", bus.o_Full, 1);
    chk("t2_ready0", bus.o_Alloc_Ready, 0);
    chk("t2_count8", bus.o_Count, 8);
    bus.i_Alloc_Valid = 1; bus.i_Alloc_New_PReg = 6'd60; bus.i_Alloc_Old_PReg = 6'd60;
    tick();
    bus.i_Alloc_Valid = 0;
    chk("t2_drop_count", bus.o_Count, 8);
    chk("t2_drop_idx", bus.o_Alloc_Index, 0);
    wb(0);
    wb(1);
    bus.i_Commit_Enable = 1; bus.i_Free_Ready = 1;
    bus.i_Alloc_Valid = 1; bus.i_Alloc_New_PReg = 6'd50; bus.i_Alloc_Old_PReg = 6'd20;
    #1;
    chk("t2_fv", bus.o_Free_Valid, 1);
    chk("t2_preg10", bus.o_Free_PReg, 10);
    chk("t2_ready_full", bus.o_Alloc_Ready, 0);
    tick();
    chk("t2_count7", bus.o_Count, 7);
    chk("t2_ready1", bus.o_Alloc_Ready, 1);
    chk("t2_idx0", bus.o_Alloc_Index, 0);
    chk("t2_preg11", bus.o_Free_PReg, 11);
    tick();
    chk("t2_count_same", bus.o_Count, 7);
    chk("t2_tail_wrap", bus.o_Alloc_Index, 1);
    chk("t2_fv_notdone", bus.o_Free_Valid, 0);
    bus.i_Alloc_Valid = 0; bus.i_Commit_Enable = 0;

    // commit gating and free-ready backpressure
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32 + i, 1 + i, 0, i);
    for (int i = 0; i < 5; i++) wb(i);
    bus.i_Free_Ready = 1;
    #1;
    chk("t3_gated", bus.o_Free_Valid, 0);
    tick();
    chk("t3_gated_count", bus.o_Count, 5);
    bus.i_Commit_Enable = 1;
    #1;
    chk("t3_fv", bus.o_Free_Valid, 1);
    chk("t3_preg1", bus.o_Free_PReg, 1);
    tick();
    chk("t3_count4", bus.o_Count, 4);
    bus.i_Free_Ready = 0;
    #1;
    chk("t3_stall_preg", bus.o_Free_PReg, 2);
    tick();
    chk("t3_stall_count", bus.o_Count, 4);
    bus.i_Free_Ready = 1;
    #1;
    chk("t3_preg2", bus.o_Free_PReg, 2);
    tick();
    chk("t3_count3", bus.o_Count, 3);
    bus.i_Commit_Enable = 0;

    // flush walk across the wrap point
    do_reset();
    for (int i = 0; i < 6; i++) alloc(20 + i, 1 + i, 0, i);
    for (int i = 0; i < 6; i++) wb(i);
    bus.i_Commit_Enable = 1; bus.i_Free_Ready = 1;
    for (int i = 0; i < 6; i++) tick();
    bus.i_Commit_Enable = 0;
    chk("t4_drained", bus.o_Empty, 1);
    for (int i = 0; i < 4; i++) alloc(40 + i, 1, 0, (6 + i) % 8);
    chk("t4_count4", bus.o_Count, 4);
    bus.i_Flush = 1; bus.i_Flush_Tail = 3'd7;
    tick();
    bus.i_Flush = 0;
    chk("t4_busy", bus.o_Busy, 1);
    chk("t4_ready0", bus.o_Alloc_Ready, 0);
    chk("t4_fv", bus.o_Free_Valid, 1);
    chk("t4_preg43", bus.o_Free_PReg, 43);
    tick();
    chk("t4_preg42", bus.o_Free_PReg, 42);
    tick();
    chk("t4_preg41", bus.o_Free_PReg, 41);
    tick();
    chk("t4_run", bus.o_Busy, 0);
    chk("t4_count1", bus.o_Count, 1);
    chk("t4_idx7", bus.o_Alloc_Index, 7);
    chk("t4_fv_done", bus.o_Free_Valid, 0);

    // flush to current tail, and flush priority over alloc/retire
    bus.i_Flush = 1; bus.i_Flush_Tail = 3'd7;
    tick();
    bus.i_Flush = 0;
    chk("t5_nowalk_busy", bus.o_Busy, 0);
    chk("t5_nowalk_fv", bus.o_Free_Valid, 0);
    chk("t5_nowalk_count", bus.o_Count, 1);
    wb(6);
    bus.i_Commit_Enable = 1; bus.i_Free_Ready = 1; bus.i_Alloc_Valid = 1;
    bus.i_Flush = 1; bus.i_Flush_Tail = 3'd7;
    #1;
    chk("t5_flush_fv", bus.o_Free_Valid, 0);
    tick();
    bus.i_Alloc_Valid = 0; bus.i_Flush = 0; bus.i_Commit_Enable = 0;
    chk("t5_count", bus.o_Count, 1);
    chk("t5_idx", bus.o_Alloc_Index, 7);
    chk("t5_busy", bus.o_Busy, 0);

    // reset abandons a walk in progress
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32 + i, 1 + i, 0, i);
    bus.i_Flush = 1; bus.i_Flush_Tail = 3'd0;
    tick();
    bus.i_Flush = 0;
    chk("t6_preg34", bus.o_Free_PReg, 34);
    bus.i_Free_Ready = 1;
    tick();
    chk("t6_preg33", bus.o_Free_PReg, 33);
    chk("t6_count2", bus.o_Count, 2);
    rst = 1'b1;
    tick();
    chk("t6_fv", bus.o_Free_Valid, 0);
    chk("t6_count", bus.o_Count, 0);
    chk("t6_empty", bus.o_Empty, 1);
    chk("t6_busy", bus.o_Busy, 0);
    rst = 1'b0;
    tick();
    chk("t6_fv_after", bus.o_Free_Valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
